// File: rtl/gold_code_spreader_if.sv
// ----------------------------------------------------------------------------
// gold_code_spreader_if
// Data-bit handshake between a bit source and the DSSS spreader.
//   data_in    : data bit to spread
//   data_last  : marks the final bit of a frame
//   data_valid : data_in/data_last are valid (driven by the source)
//   data_ready : spreader holding register is empty (driven by the spreader)
// Modports: master = bit source, slave = spreader.
// ----------------------------------------------------------------------------
interface gold_code_spreader_if;
   logic data_in;
   logic data_last;
   logic data_valid;
   logic data_ready;

   modport master (
      output data_in,
      output data_last,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_last,
      input  data_valid,
      output data_ready
   );
endinterface

// File: rtl/gold_code_spreader.sv
// ----------------------------------------------------------------------------
// gold_code_spreader
// Transmit-side DSSS spreader. Each accepted data bit is spread with a
// CODE_LEN-chip Gold code (bit 1 = code, bit 0 = inverted code), each chip held
// for SAMPLES_PER_CHIP sample ticks. Output is signed: +1, -1, 0 = idle.
//
// Ports:
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   sample_en_i : one-clk sample-tick strobe; chip stream advances only on it
//   data_if     : slave side of the data-bit valid/ready handshake
//   chip_out_o  : 2'b01 = +1, 2'b11 = -1, 2'b00 = idle (registered)
//   tx_busy_o   : high whenever the FSM is not idle
//   underrun_o  : one-clk pulse when a frame is aborted for lack of data
//
// Build option: define GOLD_SPREADER_PREAMBLE_EN to prefix every frame with
// PREAMBLE_BITS '1' bits (parameter exists only in that build).
// ----------------------------------------------------------------------------
module gold_code_spreader #(
   parameter int unsigned         CODE_LEN         = 15,
   parameter logic [CODE_LEN-1:0] CODE             = 15'h3A86,
   parameter int unsigned         SAMPLES_PER_CHIP = 4
`ifdef GOLD_SPREADER_PREAMBLE_EN
   ,
   parameter int unsigned         PREAMBLE_BITS    = 8
`endif
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_en_i,
   gold_code_spreader_if.slave        data_if,
   output logic signed [1:0]          chip_out_o,
   output logic                       tx_busy_o,
   output logic                       underrun_o
);

   localparam int unsigned SW = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;
   localparam int unsigned CW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam logic [SW-1:0] SampLast = SW'(SAMPLES_PER_CHIP - 1);
   localparam logic [CW-1:0] ChipLast = CW'(CODE_LEN - 1);

`ifdef GOLD_SPREADER_PREAMBLE_EN
   localparam int unsigned BW = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;
   localparam logic [BW-1:0] PreLast = BW'(PREAMBLE_BITS - 1);

   typedef enum logic [1:0] {StIdle, StPreamble, StData} state_e;
`else
   typedef enum logic [1:0] {StIdle, StData} state_e;
`endif

   state_e             state_q;
   logic [SW-1:0]      samp_cnt_q;
   logic [CW-1:0]      chip_cnt_q;
   logic               cur_bit_q;
   logic               cur_last_q;
   logic signed [1:0]  chip_q;
   logic               busy_q;
   logic               underrun_q;
`ifdef GOLD_SPREADER_PREAMBLE_EN
   logic [BW-1:0]      bit_cnt_q;
`endif

   logic hold_full_q, hold_full_d;
   logic hold_bit_q, hold_bit_d;
   logic hold_last_q, hold_last_d;
   logic ready_q, ready_d;

   logic          accept;
   logic          drain;
   logic          samp_wrap;
   logic          bit_boundary;
   logic [SW-1:0] samp_cnt_nxt;
   logic [CW-1:0] chip_cnt_nxt;

   // Chip value for position idx of a bit: code bit XNOR data bit -> +1 / -1.
   function automatic logic signed [1:0] chip_of(input logic [CW-1:0] idx, input logic b);
      return (CODE[idx] ~^ b) ? 2'sb01 : 2'sb11;
   endfunction

   always_comb begin
      accept       = data_if.data_valid & ready_q;
      samp_wrap    = (samp_cnt_q == SampLast);
      bit_boundary = sample_en_i & samp_wrap & (chip_cnt_q == ChipLast);
      samp_cnt_nxt = samp_wrap ? '0 : samp_cnt_q + SW'(1);
      if (!samp_wrap) begin
         chip_cnt_nxt = chip_cnt_q;
      end else if (chip_cnt_q == ChipLast) begin
         chip_cnt_nxt = '0;
      end else begin
         chip_cnt_nxt = chip_cnt_q + CW'(1);
      end

      // Drain happens exactly where the FSM loads cur_bit from the hold register.
      drain = 1'b0;
      unique case (state_q)
`ifdef GOLD_SPREADER_PREAMBLE_EN
         StIdle:     drain = 1'b0;
         StPreamble: drain = bit_boundary & (bit_cnt_q == PreLast) & hold_full_q;
`else
         StIdle:     drain = sample_en_i & hold_full_q;
`endif
         StData:     drain = bit_boundary & ~cur_last_q & hold_full_q;
         default:    drain = 1'b0;
      endcase
   end

   // One-entry holding register. Accept needs ready (= empty), so an accept
   // and a drain can never coincide.
   always_comb begin
      hold_full_d = hold_full_q;
      hold_bit_d  = hold_bit_q;
      hold_last_d = hold_last_q;
      if (accept) begin
         hold_full_d = 1'b1;
         hold_bit_d  = data_if.data_in;
         hold_last_d = data_if.data_last;
      end else if (drain) begin
         hold_full_d = 1'b0;
      end
      ready_d = ~hold_full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_full_q <= 1'b0;
         hold_bit_q  <= 1'b0;
         hold_last_q <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         hold_full_q <= hold_full_d;
         hold_bit_q  <= hold_bit_d;
         hold_last_q <= hold_last_d;
         ready_q     <= ready_d;
      end
   end

   // Spreader FSM with counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         samp_cnt_q <= '0;
         chip_cnt_q <= '0;
         cur_bit_q  <= 1'b0;
         cur_last_q <= 1'b0;
         chip_q     <= '0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
`ifdef GOLD_SPREADER_PREAMBLE_EN
         bit_cnt_q  <= '0;
`endif
      end else begin
         underrun_q <= 1'b0;
         if (sample_en_i) begin
            unique case (state_q)
               StIdle: begin
                  // Counters are already 0 here; chip 0 goes out on this edge.
                  if (hold_full_q) begin
                     busy_q <= 1'b1;
`ifdef GOLD_SPREADER_PREAMBLE_EN
                     state_q    <= StPreamble;
                     bit_cnt_q  <= '0;
                     cur_bit_q  <= 1'b1;
                     cur_last_q <= 1'b0;
                     chip_q     <= chip_of('0, 1'b1);
`else
                     state_q    <= StData;
                     cur_bit_q  <= hold_bit_q;
                     cur_last_q <= hold_last_q;
                     chip_q     <= chip_of('0, hold_bit_q);
`endif
                  end
               end
`ifdef GOLD_SPREADER_PREAMBLE_EN
               StPreamble: begin
                  samp_cnt_q <= samp_cnt_nxt;
                  chip_cnt_q <= chip_cnt_nxt;
                  if (bit_boundary && (bit_cnt_q == PreLast)) begin
                     if (hold_full_q) begin
                        state_q    <= StData;
                        cur_bit_q  <= hold_bit_q;
                        cur_last_q <= hold_last_q;
                        chip_q     <= chip_of('0, hold_bit_q);
                     end else begin
                        state_q    <= StIdle;
                        chip_q     <= '0;
                        busy_q     <= 1'b0;
                        underrun_q <= 1'b1;
                     end
                  end else begin
                     if (bit_boundary) begin
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                     end
                     chip_q <= chip_of(chip_cnt_nxt, 1'b1);
                  end
               end
`endif
               StData: begin
                  samp_cnt_q <= samp_cnt_nxt;
                  chip_cnt_q <= chip_cnt_nxt;
                  if (bit_boundary && (cur_last_q || !hold_full_q)) begin
                     // End of frame, or starved mid-frame (flagged as underrun).
                     state_q    <= StIdle;
                     chip_q     <= '0;
                     busy_q     <= 1'b0;
                     underrun_q <= ~cur_last_q;
                  end else if (bit_boundary) begin
                     cur_bit_q  <= hold_bit_q;
                     cur_last_q <= hold_last_q;
                     chip_q     <= chip_of('0, hold_bit_q);
                  end else begin
                     chip_q <= chip_of(chip_cnt_nxt, cur_bit_q);
                  end
               end
               default: begin
                  state_q <= StIdle;
                  chip_q  <= '0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign chip_out_o         = chip_q;
   assign tx_busy_o          = busy_q;
   assign underrun_o         = underrun_q;
   assign data_if.data_ready = ready_q;

endmodule

// File: tb/tb_gold_code_spreader.sv
// ----------------------------------------------------------------------------
// tb_gold_code_spreader
// Table-driven bench for gold_code_spreader. Expected chips are queued when a
// bit is accepted and popped as the DUT emits non-zero samples.
// ----------------------------------------------------------------------------
module tb_gold_code_spreader;

   localparam int CodeLen = 15;
   localparam int Spc     = 4;
`ifdef GOLD_SPREADER_PREAMBLE_EN
   localparam int Pre = 2;
`else
   localparam int Pre = 0;
`endif

   typedef struct {
      string      name;
      logic [2:0] bits;
      int         nbits;
      logic       late;
      int         div;
      int         exp_ur;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              sample_en;
   logic signed [1:0] chip_out;
   logic              tx_busy;
   logic              underrun;

   gold_code_spreader_if dif ();

`ifdef GOLD_SPREADER_PREAMBLE_EN
   gold_code_spreader #(.PREAMBLE_BITS(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_en_i (sample_en),
      .data_if     (dif),
      .chip_out_o  (chip_out),
      .tx_busy_o   (tx_busy),
      .underrun_o  (underrun)
   );
`else
   gold_code_spreader dut (
      .clk         (clk),
      .rst         (rst),
      .sample_en_i (sample_en),
      .data_if     (dif),
      .chip_out_o  (chip_out),
      .tx_busy_o   (tx_busy),
      .underrun_o  (underrun)
   );
`endif

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int send_order[CodeLen] = '{-1, 1, 1, -1, -1, -1, -1, 1, -1, 1, -1, 1, 1, 1, -1};
   int exp_q[$];
   int div_n, div_cnt;
   int busy_clks, ur_cnt, run, max_run, prev_chip;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; monitor outputs #1 after the edge, then drive sample_en.
   task automatic tick(output logic acc);
      logic se_was, acc_l;
      se_was = sample_en;
      acc_l  = dif.data_valid && dif.data_ready;
      @(posedge clk);
      #1;
      if (tx_busy) busy_clks++;
      if (underrun) ur_cnt++;
      if (se_was) begin
         if (chip_out != 0) begin
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) check("extra_chip", int'(chip_out), 0);
            else check("chip", int'(chip_out), exp_q.pop_front());
         end else begin
            run = 0;
         end
      end else begin
         check("freeze", int'(chip_out), prev_chip);
      end
      prev_chip = int'(chip_out);
      if (acc_l) check("ready_drop", int'(dif.data_ready), 0);
      div_cnt   = (div_cnt + 1) % div_n;
      sample_en = (div_cnt == 0);
      acc       = acc_l;
   endtask

   task automatic push_bit(input logic b, input logic fresh);
      if (fresh) begin
         for (int p = 0; p < Pre; p++)
            for (int c = 0; c < CodeLen; c++)
               for (int s = 0; s < Spc; s++) exp_q.push_back(send_order[c]);
      end
      for (int c = 0; c < CodeLen; c++)
         for (int s = 0; s < Spc; s++) exp_q.push_back(b ? send_order[c] : -send_order[c]);
   endtask

   task automatic reset_dut(input int d);
      rst            = 1'b1;
      dif.data_valid = 1'b0;
      dif.data_in    = 1'b0;
      dif.data_last  = 1'b0;
      div_n          = d;
      div_cnt        = 0;
      sample_en      = 1'b1;
      @(posedge clk);
      #1;
      check("rst_hold_chip", int'(chip_out), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_chip", int'(chip_out), 0);
      check("reset_busy", int'(tx_busy), 0);
      check("reset_underrun", int'(underrun), 0);
      check("reset_ready", int'(dif.data_ready), 1);
      prev_chip = 0;
      exp_q.delete();
      busy_clks = 0;
      ur_cnt    = 0;
      run       = 0;
      max_run   = 0;
   endtask

   task automatic present(input vec_t v, input int i);
      dif.data_valid = 1'b1;
      dif.data_in    = v.bits[i];
      dif.data_last  = (i == v.nbits - 1);
   endtask

   task automatic run_vec(input vec_t v);
      int   idx;
      logic acc, waiting, done;
      int   frames;
      idx     = 0;
      waiting = 1'b0;
      done    = 1'b0;
      frames  = v.late ? 2 : 1;
      reset_dut(v.div);
      present(v, 0);
      for (int budget = 0; budget < 4000 * v.div; budget++) begin
         tick(acc);
         if (acc) begin
            push_bit(v.bits[idx], (idx == 0) || v.late);
            idx++;
            if (idx < v.nbits && !v.late) begin
               present(v, idx);
            end else begin
               dif.data_valid = 1'b0;
               waiting        = (idx < v.nbits);
            end
         end else if (waiting && !tx_busy && exp_q.size() == 0) begin
            present(v, idx);
            waiting = 1'b0;
         end
         if (idx == v.nbits && exp_q.size() == 0 && !tx_busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check({v.name, "_timeout"}, 0, 1);
      for (int k = 0; k < 8 * v.div; k++) tick(acc);
      check({v.name, "_max_run"}, max_run, ((v.late ? 1 : v.nbits) + Pre) * CodeLen * Spc);
      check({v.name, "_busy_clks"}, busy_clks,
            (v.nbits + frames * Pre) * CodeLen * Spc * v.div);
      check({v.name, "_underrun"}, ur_cnt, v.exp_ur);
      check({v.name, "_queue_left"}, exp_q.size(), 0);
      check({v.name, "_idle_chip"}, int'(chip_out), 0);
      check({v.name, "_ready_end"}, int'(dif.data_ready), 1);
   endtask

   vec_t vecs[5];

   initial begin
      logic acc;
      int   pushed;
      vecs[0] = '{name: "one_bit1",  bits: 3'b001, nbits: 1, late: 1'b0, div: 1, exp_ur: 0};
      vecs[1] = '{name: "one_bit0",  bits: 3'b000, nbits: 1, late: 1'b0, div: 1, exp_ur: 0};
      vecs[2] = '{name: "stream101", bits: 3'b101, nbits: 3, late: 1'b0, div: 1, exp_ur: 0};
      vecs[3] = '{name: "late_2nd",  bits: 3'b001, nbits: 2, late: 1'b1, div: 1, exp_ur: 1};
      vecs[4] = '{name: "div3_10",   bits: 3'b001, nbits: 2, late: 1'b0, div: 3, exp_ur: 0};

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Mid-frame asynchronous reset with sample_en every 3rd clock.
      reset_dut(3);
      dif.data_valid = 1'b1;
      dif.data_in    = 1'b1;
      dif.data_last  = 1'b1;
      pushed         = 0;
      for (int budget = 0; budget < 2000; budget++) begin
         tick(acc);
         if (acc) begin
            push_bit(1'b1, 1'b1);
            pushed         = exp_q.size();
            dif.data_valid = 1'b0;
         end
         if (pushed != 0 && (pushed - exp_q.size()) >= 30) break;
      end
      check("rst_reached_30", pushed - exp_q.size(), 30);
      check("rst_pre_chip_nz", int'(chip_out != 0), 1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_chip", int'(chip_out), 0);
      check("rst_async_busy", int'(tx_busy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready_next", int'(dif.data_ready), 1);
      exp_q.delete();
      prev_chip = int'(chip_out);
      for (int k = 0; k < 30; k++) tick(acc);
      check("rst_discarded", int'(chip_out), 0);
      check("rst_no_busy", int'(tx_busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gold_code_spreader.md
Name: gold_code_spreader

Overview:
- Transmit-side DSSS spreader; the counterpart of the modem's Gold-code correlator receive path.
- Accepts data bits over a valid/ready handshake and spreads each bit with the 15-chip Gold code: bit 1 sends the code, bit 0 sends the inverted code.
- Holds each chip for SAMPLES_PER_CHIP sample ticks, so the receiver's 4-phase round-robin sampling sees every chip 4 times.
- Output feeds the transducer driver as signed {+1, -1, 0 = idle}.

Parameters:
- CODE_LEN, 15, chips per bit.
- CODE, 15'h3A86, spreading code; bit i is the chip sent i-th; 1 = +1, 0 = -1. Send order: -1,1,1,-1,-1,-1,-1,1,-1,1,-1,1,1,1,-1.
- SAMPLES_PER_CHIP, 4, sample ticks per chip.
- PREAMBLE_BITS, 8, number of '1' bits sent before the first data bit (only with PREAMBLE_EN).

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- sample_en  in  1  one-clk sample-tick strobe; the chip output advances only on clocks where it is high.
- data_in  in  1  data bit.
- data_last  in  1  marks the final bit of a frame.
- data_valid  in  1  data_in/data_last are valid.
- data_ready  out  1  the one-entry holding register is empty.
- chip_out  out  2 (signed)  2'b01 = +1, 2'b11 = -1, 2'b00 = idle.
- tx_busy  out  1  high in any state other than IDLE.
- underrun  out  1  one-clk pulse on a mid-frame starvation abort.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; hold register empty; all counters = 0; chip_out=0; tx_busy=0; underrun=0; data_ready=1 from the first clock after reset.
- Holding register:
  - Accepts {data_in, data_last} when data_valid && data_ready, on any clk, independent of sample_en.
  - data_ready = !hold_full, registered.
  - The spreader drains the register at a bit boundary. A drain and an accept may not occur on the same clk; the accept is ordered after the drain, which is guaranteed because data_ready was 0 while the register was full.
- Counters (advance only when sample_en=1):
  - samp_cnt: 0..SAMPLES_PER_CHIP-1.
  - chip_cnt: 0..CODE_LEN-1, increments when samp_cnt wraps.
  - bit boundary = the sample_en tick where samp_cnt=SAMPLES_PER_CHIP-1 and chip_cnt=CODE_LEN-1; both counters wrap to 0 there.
- Chip value: chip = CODE[chip_cnt] XNOR cur_bit, mapped to +1/-1. chip_out is registered and updates only on sample_en ticks.
- FSM states:
  - IDLE: chip_out=0, counters held at 0. On a sample_en tick with hold full, load cur_bit/cur_last from hold, empty hold, go to DATA. chip_out shows chip0 of that bit on the same edge. Latency from accept to the first chip = the next sample_en tick.
  - DATA: at a bit boundary:
    - cur_last=1: go to IDLE, chip_out=0 on that edge, even if hold is full (the next frame starts on the following tick).
    - else hold full: load the next bit; the chip stream continues with no gap.
    - else (starved): go to IDLE, chip_out=0, pulse underrun for one clk.
- Each bit lasts exactly CODE_LEN*SAMPLES_PER_CHIP = 60 sample ticks.
- sample_en held low: outputs and counters freeze; handshake still operates.
- rst asserted mid-frame: output returns to 0 immediately and the partial bit is discarded.

Optional Feature:
- Macro: GOLD_SPREADER_PREAMBLE_EN.
- Defined: the IDLE exit goes to a PREAMBLE state first, which sends PREAMBLE_BITS bits of value 1 (positive code). It uses a bit counter 0..PREAMBLE_BITS-1, then moves to DATA and loads hold at the last preamble bit boundary. Hold is not drained until then; data_ready stays 0 while it is full. tx_busy is high in PREAMBLE. Starvation at the end of the preamble is handled as in DATA (IDLE + underrun).
- Undefined: no PREAMBLE state or bit counter; IDLE goes directly to DATA as described above.

Test Plan:
- Single bit 1 with data_last=1, sample_en every clk -> chip_out follows the send-order chips, each for 4 clks (60 clks total), then 0; tx_busy high for exactly 60 clks.
- Single bit 0 with last -> the exact sign-inverted sequence +1,-1,-1,+1,... each for 4 clks; underrun stays 0.
- Stream 1,0,1 (last on the third bit), valid always high -> 180 contiguous non-zero samples with no gap at the boundaries; data_ready drops within 1 clk of each accept and returns after each drain.
- Two bits with the second presented late (after the bit boundary) -> output 0 from that boundary onward, underrun pulses for exactly 1 clk, state IDLE; the late bit then starts a fresh 60-sample burst.
- sample_en asserted every 3rd clk -> each chip lasts 12 clks; rst asserted at sample 30 -> chip_out=0 immediately, data_ready=1 the next clk.
- With GOLD_SPREADER_PREAMBLE_EN and PREAMBLE_BITS=2, data bit 0 with last -> 120 samples of the positive code, then 60 samples of the inverted code, then 0.
